// File: rtl/prm_oblgc_chk_engine.sv
// prm_oblgc_chk_engine: run-time loadable cube-table obstacle checker.
// Optional macro PRM_OBLGC_EARLY_EXIT_EN ends the scan at the first hit group.
module prm_oblgc_chk_engine #(
  parameter int IN_W  = 15,
  parameter int DEPTH = 256,
  parameter int LANES = 4,
  parameter int ID_W  = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [IN_W-1:0] cfg_care,
  input  logic [IN_W-1:0] cfg_val,
  input  logic            cfg_en,
  input  logic            cfg_clr,
  output logic            busy,
  output logic            cfg_err,
  input  logic            q_valid,
  output logic            q_ready,
  input  logic [IN_W-1:0] q_vec,
  input  logic [ID_W-1:0] q_id,
  output logic            r_valid,
  input  logic            r_ready,
  output logic            r_mask,
  output logic [AW-1:0]   r_hit_idx,
  output logic [ID_W-1:0] r_id
);

  localparam int BW = AW + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [IN_W-1:0] care_mem [DEPTH];
  logic [IN_W-1:0] val_mem  [DEPTH];
  logic [DEPTH-1:0] en;
  logic [IN_W-1:0] qv;
  logic [BW-1:0]   base;
  logic            grp_hit;
  logic [AW-1:0]   grp_idx;
  logic [AW-1:0]   li;
  logic            last;
  logic            accept;
  logic            cfg_ok;

  assign q_ready = rst_n && (state == IDLE);
  assign accept  = q_valid && q_ready;
  assign busy    = (state != IDLE);
  assign r_valid = (state == DONE);
  assign cfg_ok  = (state == IDLE);
  assign last    = (base == BW'(DEPTH - LANES));

  // Walk lanes high to low so the lowest matching index wins.
  always_comb begin
    grp_hit = 1'b0;
    grp_idx = '0;
    li      = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      li = base[AW-1:0] + AW'(l);
      if (en[li] && (((qv ^ val_mem[li]) & care_mem[li]) == '0)) begin
        grp_hit = 1'b1;
        grp_idx = li;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = SCAN;
`ifdef PRM_OBLGC_EARLY_EXIT_EN
      SCAN: if (grp_hit || last) state_nx = DONE;
`else
      SCAN: if (last) state_nx = DONE;
`endif
      DONE: if (r_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en        <= '0;
      cfg_err   <= 1'b0;
      r_mask    <= 1'b0;
      r_hit_idx <= '0;
      r_id      <= '0;
      base      <= '0;
      qv        <= '0;
    end else begin
      // Clear first; a same-cycle write then re-arms its own entry.
      if (cfg_ok) begin
        if (cfg_clr) en <= '0;
        if (cfg_we)  en[cfg_addr] <= cfg_en;
      end else if (cfg_we || cfg_clr) begin
        cfg_err <= 1'b1;
      end
      if (accept) begin
        qv        <= q_vec;
        r_id      <= q_id;
        r_mask    <= 1'b0;
        r_hit_idx <= '0;
        base      <= '0;
      end
      if (state == SCAN) begin
        if (grp_hit && !r_mask) begin
          r_mask    <= 1'b1;
          r_hit_idx <= grp_idx;
        end
        base <= base + BW'(LANES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && cfg_ok && cfg_we) begin
      care_mem[cfg_addr] <= cfg_care;
      val_mem[cfg_addr]  <= cfg_val;
    end
  end

endmodule

// File: tb/tb_prm_oblgc_chk_engine.sv
// tb_prm_oblgc_chk_engine: directed scoreboard bench for the cube checker.
// Expected results are queued at issue and popped when r_valid appears.
module tb_prm_oblgc_chk_engine;

  localparam int NG = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [14:0] cfg_care = '0;
  logic [14:0] cfg_val = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_clr = 1'b0;
  logic        busy;
  logic        cfg_err;
  logic        q_valid = 1'b0;
  logic        q_ready;
  logic [14:0] q_vec = '0;
  logic [7:0]  q_id = '0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic        r_mask;
  logic [7:0]  r_hit_idx;
  logic [7:0]  r_id;

  typedef struct {
    logic       mask;
    logic [7:0] idx;
    logic [7:0] id;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  prm_oblgc_chk_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_care(cfg_care), .cfg_val(cfg_val),
    .cfg_en(cfg_en), .cfg_clr(cfg_clr),
    .busy(busy), .cfg_err(cfg_err),
    .q_valid(q_valid), .q_ready(q_ready),
    .q_vec(q_vec), .q_id(q_id),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_mask(r_mask), .r_hit_idx(r_hit_idx),
    .r_id(r_id)
  );

  always #5 clk = ~clk;

  function automatic int lat_hit(int g);
`ifdef PRM_OBLGC_EARLY_EXIT_EN
    return g + 1;
`else
    return NG + 0 * g;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(int a, logic [14:0] c, logic [14:0] v, logic e);
    cfg_we = 1'b1;
    cfg_addr = 8'(a);
    cfg_care = c;
    cfg_val = v;
    cfg_en = e;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic issue(logic [14:0] v, logic [7:0] id,
                       logic m, logic [7:0] ix, int lat);
    exp_t e;
    e.mask = m;
    e.idx = ix;
    e.id = id;
    e.lat = lat;
    sb.push_back(e);
    q_vec = v;
    q_id = id;
    q_valid = 1'b1;
    #1 chk("q_ready_idle", q_ready, 1);
    @(posedge clk);
    #1 q_valid = 1'b0;
  endtask

  task automatic await(string tag, int hold, bit poke);
    exp_t e;
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!r_valid && n < 200);
    chk({tag, "_rvalid"}, r_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_lat"}, n, e.lat);
    chk({tag, "_mask"}, r_mask, e.mask);
    chk({tag, "_idx"}, r_hit_idx, e.idx);
    chk({tag, "_id"}, r_id, e.id);
    for (int k = 0; k < hold; k++) begin
      if (poke && k == 0) begin
        cfg_we = 1'b1;
        cfg_addr = 8'd0;
        cfg_care = 15'h7FFF;
        cfg_val = 15'h0000;
        cfg_en = 1'b0;
      end
      @(posedge clk);
      #1 cfg_we = 1'b0;
      chk({tag, "_hold_v"}, r_valid, 1);
      chk({tag, "_hold_m"}, r_mask, e.mask);
      chk({tag, "_hold_i"}, r_hit_idx, e.idx);
      chk({tag, "_hold_id"}, r_id, e.id);
      chk({tag, "_hold_qr"}, q_ready, 0);
    end
    if (poke) chk({tag, "_cfg_err"}, cfg_err, 1);
    r_ready = 1'b1;
    #1 chk({tag, "_qr_comb"}, q_ready, 0);
    @(posedge clk);
    #1 r_ready = 1'b0;
    chk({tag, "_rv_drop"}, r_valid, 0);
    chk({tag, "_qr_next"}, q_ready, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_rv", r_valid, 0);
    chk("rst_mask", r_mask, 0);
    chk("rst_idx", r_hit_idx, 0);
    chk("rst_id", r_id, 0);
    chk("rst_qr", q_ready, 0);
    rst_n = 1'b1;
    #1 chk("rel_qr", q_ready, 1);
    @(posedge clk);
    #1;

    wr(0, 15'h7FFF, 15'h1234, 1'b1);
    issue(15'h1234, 8'hA5, 1'b1, 8'd0, lat_hit(0));
    await("e0", 0, 0);

    wr(9, 15'h00F0, 15'h0050, 1'b1);
    issue(15'h7F5F, 8'h11, 1'b1, 8'd9, lat_hit(2));
    await("e9", 0, 0);
    issue(15'h7F6F, 8'h12, 1'b0, 8'd0, NG);
    await("miss", 0, 0);

    wr(5, 15'h0001, 15'h0001, 1'b1);
    wr(6, 15'h7FFF, 15'h0001, 1'b1);
    issue(15'h0001, 8'h13, 1'b1, 8'd5, lat_hit(1));
    await("low", 0, 0);

    issue(15'h1234, 8'h3C, 1'b1, 8'd0, lat_hit(0));
    await("hold", 10, 1);
    issue(15'h1234, 8'h3D, 1'b1, 8'd0, lat_hit(0));
    await("unch", 0, 0);
    chk("err_sticky", cfg_err, 1);

    q_vec = 15'h7F6F;
    q_id = 8'h77;
    q_valid = 1'b1;
    @(posedge clk);
    #1 q_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_rv", r_valid, 0);
    chk("mrst_err", cfg_err, 0);
    chk("mrst_id", r_id, 0);
    chk("mrst_qr", q_ready, 0);
    rst_n = 1'b1;
    #1;
    issue(15'h1234, 8'h44, 1'b0, 8'd0, NG);
    await("empty", 0, 0);

    wr(0, 15'h7FFF, 15'h1234, 1'b1);
    begin
      exp_t e;
      e.mask = 1'b1;
      e.idx = 8'd3;
      e.id = 8'h5A;
      e.lat = lat_hit(0);
      sb.push_back(e);
    end
    cfg_clr = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = 8'd3;
    cfg_care = 15'h0000;
    cfg_val = 15'h0000;
    cfg_en = 1'b1;
    q_vec = 15'h1234;
    q_id = 8'h5A;
    q_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_clr = 1'b0;
    cfg_we = 1'b0;
    q_valid = 1'b0;
    await("clrwe", 0, 0);
    chk("no_err", cfg_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
